// File: rtl/gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_pkg
// Description : Shared constants for the APB GPIO controller: register
//               offsets, interrupt encodings and a byte-strobe helper.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_pkg;

    localparam int c_MAX_PINS = 32;

    localparam logic [31:0] c_OFF_DOUT     = 32'h00;
    localparam logic [31:0] c_OFF_DIR      = 32'h04;
    localparam logic [31:0] c_OFF_DIN      = 32'h08;
    localparam logic [31:0] c_OFF_IRQ_EN   = 32'h0C;
    localparam logic [31:0] c_OFF_IRQ_TYPE = 32'h10;
    localparam logic [31:0] c_OFF_IRQ_POL  = 32'h14;
    localparam logic [31:0] c_OFF_IRQ_STAT = 32'h18;
    localparam logic [31:0] c_OFF_DOUT_SET = 32'h1C;
    localparam logic [31:0] c_OFF_DOUT_CLR = 32'h20;

    localparam logic c_IRQ_TYPE_LEVEL = 1'b0;
    localparam logic c_IRQ_TYPE_EDGE  = 1'b1;
    localparam logic c_IRQ_POL_LOW    = 1'b0;
    localparam logic c_IRQ_POL_HIGH   = 1'b1;

    // Expand the four byte strobes into a 32-bit bit mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : gpio_sync_edge
// Description : Multi-flop input synchroniser with a one-sample history,
//               producing the synced value plus rise/fall pulses per pin.
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_sync_edge #(
    parameter int NUM_PINS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PINS-1:0] i_din,
    output logic [NUM_PINS-1:0] o_sync,
    output logic [NUM_PINS-1:0] o_rise,
    output logic [NUM_PINS-1:0] o_fall
);

    logic [SYNC_STAGES-1:0][NUM_PINS-1:0] r_stage;
    logic [NUM_PINS-1:0]                  r_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stage <= '0;
            r_prev  <= '0;
        end else begin
            r_stage[0] <= i_din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
            r_prev <= r_stage[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_stage[SYNC_STAGES-1];
    assign o_rise = o_sync & ~r_prev;
    assign o_fall = ~o_sync & r_prev;

endmodule
`default_nettype wire

// File: rtl/apb_gpio_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : apb_gpio_ctrl
// Description : APB3 GPIO slave with direction control, atomic set/clear,
//               synchronised inputs and per-pin level/edge interrupts.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_gpio_ctrl
    import gpio_pkg::*;
#(
    parameter int NUM_PINS    = 32,
    parameter int ADDR_W      = 6,
    parameter int SYNC_STAGES = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                PCLK,
    input  logic                PRESET,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [ADDR_W-1:0]   PADDR,
    input  logic [31:0]         PWDATA,
    input  logic [3:0]          PSTRB,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic [NUM_PINS-1:0] gpio_i,
    output logic [NUM_PINS-1:0] gpio_o,
    output logic [NUM_PINS-1:0] gpio_oe,
    output logic                irq_o
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;

    logic [1:0]          r_state;
    logic [2:0]          r_wait_cnt;
    logic [NUM_PINS-1:0] r_dout, r_dir, r_en, r_type, r_pol, r_stat;
    logic                r_irq;

    logic                w_access, w_ready, w_err, w_mapped;
    logic                w_wr_ok, w_rd_ok;
    logic [31:0]         w_addr, w_rdata, w_bm;
    logic [NUM_PINS-1:0] w_bm_p, w_wd_p, w_clr, w_set;
    logic [NUM_PINS-1:0] w_sync, w_rise, w_fall;

    gpio_sync_edge #(
        .NUM_PINS    (NUM_PINS),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (PCLK),
        .rst    (PRESET),
        .i_din  (gpio_i),
        .o_sync (w_sync),
        .o_rise (w_rise),
        .o_fall (w_fall)
    );

    // An access phase only counts after a setup phase seen since reset.
    assign w_access = PSEL & PENABLE & (r_state != c_ST_IDLE);
    assign w_ready  = w_access & (r_wait_cnt == 3'd0);

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state    <= c_ST_IDLE;
            r_wait_cnt <= 3'd0;
        end else if (!PSEL) begin
            r_state <= c_ST_IDLE;
        end else if (!PENABLE) begin
            r_state    <= c_ST_SETUP;
            r_wait_cnt <= 3'(WAIT_STATES);
        end else if (r_state != c_ST_IDLE) begin
            if (r_wait_cnt == 3'd0) begin
                r_state <= c_ST_IDLE;
            end else begin
                r_wait_cnt <= r_wait_cnt - 3'd1;
                r_state    <= c_ST_ACCESS;
            end
        end
    end

    assign w_addr = 32'(PADDR);
    assign w_bm   = strb_mask(PSTRB);
    assign w_bm_p = w_bm[NUM_PINS-1:0];
    assign w_wd_p = PWDATA[NUM_PINS-1:0] & w_bm_p;

    always_comb begin
        w_mapped = 1'b1;
        w_rdata  = 32'h0;
        case (w_addr)
            c_OFF_DOUT:     w_rdata = 32'(r_dout);
            c_OFF_DIR:      w_rdata = 32'(r_dir);
            c_OFF_DIN:      w_rdata = 32'(w_sync);
            c_OFF_IRQ_EN:   w_rdata = 32'(r_en);
            c_OFF_IRQ_TYPE: w_rdata = 32'(r_type);
            c_OFF_IRQ_POL:  w_rdata = 32'(r_pol);
            c_OFF_IRQ_STAT: w_rdata = 32'(r_stat);
            c_OFF_DOUT_SET: w_rdata = 32'h0;
            c_OFF_DOUT_CLR: w_rdata = 32'h0;
            default:        w_mapped = 1'b0;
        endcase
    end

    assign w_err   = (PADDR[1:0] != 2'b00) | ~w_mapped | (PWRITE & (w_addr == c_OFF_DIN));
    assign w_wr_ok = w_ready & PWRITE & ~w_err;
    assign w_rd_ok = w_ready & ~PWRITE & ~w_err;

    assign PREADY  = w_ready;
    assign PSLVERR = w_ready & w_err;
    assign PRDATA  = w_rd_ok ? w_rdata : 32'h0;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_dout <= '0;
            r_dir  <= '0;
            r_en   <= '0;
            r_type <= '0;
            r_pol  <= '0;
        end else if (w_wr_ok) begin
            case (w_addr)
                c_OFF_DOUT:     r_dout <= (r_dout & ~w_bm_p) | w_wd_p;
                c_OFF_DIR:      r_dir  <= (r_dir  & ~w_bm_p) | w_wd_p;
                c_OFF_IRQ_EN:   r_en   <= (r_en   & ~w_bm_p) | w_wd_p;
                c_OFF_IRQ_TYPE: r_type <= (r_type & ~w_bm_p) | w_wd_p;
                c_OFF_IRQ_POL:  r_pol  <= (r_pol  & ~w_bm_p) | w_wd_p;
                c_OFF_DOUT_SET: r_dout <= r_dout | w_wd_p;
                c_OFF_DOUT_CLR: r_dout <= r_dout & ~w_wd_p;
                default:        ;
            endcase
        end
    end

    always_comb begin
        w_set = '0;
        for (int i = 0; i < NUM_PINS; i++) begin
            if (r_type[i] == c_IRQ_TYPE_EDGE) begin
                w_set[i] = r_en[i] & ((r_pol[i] == c_IRQ_POL_HIGH) ? w_rise[i] : w_fall[i]);
            end else begin
                w_set[i] = r_en[i] & (w_sync[i] == r_pol[i]);
            end
        end
    end

    assign w_clr = (w_wr_ok && (w_addr == c_OFF_IRQ_STAT)) ? w_wd_p : '0;

    // A set condition in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_stat <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_stat <= (r_stat & ~w_clr) | w_set;
            r_irq  <= |(r_stat & r_en);
        end
    end

    assign gpio_o  = r_dout;
    assign gpio_oe = r_dir;
    assign irq_o   = r_irq;

endmodule
`default_nettype wire

// File: doc/apb_gpio_ctrl.md
Name: apb_gpio_ctrl

Overview:
Parametrised APB3 GPIO slave, successor to the fixed 32-pin gpio. Adds per-pin direction, atomic set/clear of outputs, synchronised inputs, and a per-pin edge/level interrupt with W1C status. Sits behind the APB master on one PSEL line. Pin tristate resolution stays outside the block, which exposes separate in/out/oe vectors.

Parameters:
NUM_PINS, 32, number of GPIO pins, 1..32; register bits at and above NUM_PINS read 0 and ignore writes
ADDR_W, 6, PADDR width; byte address, word aligned
SYNC_STAGES, 2, input synchroniser depth, >=2
WAIT_STATES, 0, access-phase wait cycles inserted before PREADY, 0..7

Ports:
PCLK  in  1  clock
PRESET  in  1  asynchronous active-high reset
PSEL  in  1  slave select
PENABLE  in  1  APB access phase
PWRITE  in  1  1=write, 0=read
PADDR  in  ADDR_W  byte address
PWDATA  in  32  write data
PSTRB  in  4  byte write strobes
PRDATA  out  32  read data, valid when PREADY=1 in a read access
PREADY  out  1  transfer complete
PSLVERR  out  1  error, valid with PREADY
gpio_i  in  NUM_PINS  pad inputs, asynchronous
gpio_o  out  NUM_PINS  pad output values
gpio_oe  out  NUM_PINS  1=drive pad
irq_o  out  1  registered interrupt request

Behaviour:
- Register map, word offsets: 0x00 DOUT RW; 0x04 DIR RW (drives gpio_oe); 0x08 DIN RO (synchronised gpio_i); 0x0C IRQ_EN RW; 0x10 IRQ_TYPE RW (0=level, 1=edge); 0x14 IRQ_POL RW (0=low/falling, 1=high/rising); 0x18 IRQ_STAT RW1C; 0x1C DOUT_SET WO; 0x20 DOUT_CLR WO.
- Reset (asynchronous, PRESET=1): all registers 0, synchroniser and edge history 0, gpio_o=0, gpio_oe=0, irq_o=0, PRDATA=0, PREADY=0, PSLVERR=0, wait counter 0. Reset asserted mid-transfer aborts the transfer. No register is updated by it.
- Handshake: setup phase (PSEL & !PENABLE) loads wait counter with WAIT_STATES. In access phase (PSEL & PENABLE) the counter decrements to 0. PREADY = access & (count==0), so WAIT_STATES=0 completes in one access cycle. PREADY=0 outside access.
- Commit: a write takes effect on the PCLK edge where PSEL & PENABLE & PREADY & PWRITE. Read data is combinational from current register state, gated to 0 unless a read completes.
- PSTRB: byte lane n updates bits 8n+7:8n of RW registers. SET/CLR/W1C act only on strobed lanes.
- DOUT_SET: DOUT |= wdata. DOUT_CLR: DOUT &= ~wdata. Both read as 0.
- PSLVERR=1 with PREADY for: unmapped offset, misaligned PADDR[1:0]!=0, write to DIN. On error, no register changes and PRDATA=0.
- DIN: gpio_i passes through SYNC_STAGES flops, giving SYNC_STAGES cycles of latency. DIN reflects the pin regardless of DIR.
- Interrupt detect per pin i, gated by IRQ_EN[i], using synced s and previous sample p:
  - level: set when s==POL
  - edge: rising when POL=1 (s & ~p); falling when POL=0 (~s & p)
- IRQ_STAT is sticky. A W1C of bit i clears it unless a set condition for i holds the same cycle; set wins. An active level source therefore re-sets the bit immediately.
- Clearing IRQ_EN[i] does not clear IRQ_STAT[i].
- irq_o registered: next = |(IRQ_STAT & IRQ_EN), so it lags STAT by one cycle.
- Changing TYPE/POL can produce a spurious edge. Software clears STAT afterwards; no hardware masking.

Decomposition:
- Package gpio_pkg: register offset localparams, IRQ_TYPE/IRQ_POL encodings, MAX_PINS=32.
- Sub-module gpio_sync_edge: parametrised by NUM_PINS and SYNC_STAGES. Outputs synced value plus rise and fall pulses. Instantiated once.
- APB FSM (IDLE/SETUP/ACCESS), register file and IRQ logic live in apb_gpio_ctrl.

Test Plan:
- Reset then read all offsets -> all 0, PSLVERR=0; gpio_oe=0, irq_o=0.
- Write DIR=0x0000FFFF, DOUT=0xA5A5A5A5 with PSTRB=4'b0011 -> gpio_oe=0x0000FFFF, gpio_o=0x0000A5A5; DOUT_SET 0x00010000 -> gpio_o=0x0001A5A5; DOUT_CLR 0x00000005 -> 0x0001A5A0.
- WAIT_STATES=3: write DOUT -> PREADY low 3 access cycles, high on 4th; DOUT updates only on that edge. Read 0x24 -> PSLVERR=1, PRDATA=0. Write 0x08 -> PSLVERR=1.
- IRQ_EN[3]=1, TYPE edge, POL=1; drive gpio_i[3] 0->1 -> IRQ_STAT=0x8 after SYNC_STAGES+1 cycles, irq_o one cycle later. W1C 0x8 -> STAT=0, irq_o=0 next cycle.
- Level-high on pin 5 held at 1; W1C 0x20 -> STAT[5] stays 1 (set wins). Drop pin, W1C -> cleared.
- Assert PRESET during access phase of a DOUT write -> DOUT remains 0, PREADY=0 immediately; next transfer completes normally.
